gfx_pattern_gen: RTL and testbench

//  Multi-mode, parametrised pixel-stream source for the gfx pipeline. Emits one frame (or repeated frames) of
//  (x, y, color, last) beats on a pvalid/pready handshake into gfx_vga's gfx_* input. Supersedes the

---
 rtl/gfx_pattern_pkg.sv | 19 +
 rtl/gfx_raster_counter.sv | 87 ++++++++
 rtl/gfx_pattern_gen.sv | 137 +++++++++++++
 tb/tb_gfx_pattern_gen.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gfx_pattern_pkg.sv
// Shared types and constants for the gfx pattern generator and its raster counter.
package gfx_pattern_pkg;

  typedef enum logic [1:0] {
    MODE_SOLID   = 2'd0,
    MODE_HGRAD   = 2'd1,
    MODE_CHECKER = 2'd2,
    MODE_BARS    = 2'd3
  } mode_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int unsigned NUM_BARS     = 8;
  localparam int unsigned BAR_IDX_BITS = 3;

endpackage

// File: rtl/gfx_raster_counter.sv
// Raster position tracker: x/y coordinates, colour-bar index and a registered
// end-of-frame flag. Next-state values are exported so the parent can register
// colour in the same cycle as the coordinates.
module gfx_raster_counter
  import gfx_pattern_pkg::*;
#(
  parameter int unsigned FB_WIDTH  = 640,
  parameter int unsigned FB_HEIGHT = 480,
  parameter int unsigned X_BITS    = $clog2(FB_WIDTH),
  parameter int unsigned Y_BITS    = $clog2(FB_HEIGHT)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    advance,
  output logic [X_BITS-1:0]       x,
  output logic [Y_BITS-1:0]       y,
  output logic                    last,
  output logic [X_BITS-1:0]       x_nxt_c,
  output logic [Y_BITS-1:0]       y_nxt_c,
  output logic [BAR_IDX_BITS-1:0] bar_nxt_c
);

  // Bars are BAR_W pixels wide; a pixel counter replaces a divider.
  localparam int unsigned BAR_W        = ((FB_WIDTH / NUM_BARS) == 0) ? 1 : (FB_WIDTH / NUM_BARS);
  localparam int unsigned BAR_CNT_BITS = (BAR_W > 1) ? $clog2(BAR_W) : 1;

  localparam logic [X_BITS-1:0]       X_MAX       = X_BITS'(FB_WIDTH - 1);
  localparam logic [Y_BITS-1:0]       Y_MAX       = Y_BITS'(FB_HEIGHT - 1);
  localparam logic [BAR_CNT_BITS-1:0] BAR_CNT_MAX = BAR_CNT_BITS'(BAR_W - 1);
  localparam logic [BAR_IDX_BITS-1:0] BAR_MAX     = BAR_IDX_BITS'(NUM_BARS - 1);

  logic [BAR_IDX_BITS-1:0] bar;
  logic [BAR_CNT_BITS-1:0] bar_cnt;
  logic [BAR_CNT_BITS-1:0] bar_cnt_nxt;
  logic                    last_nxt;

  // Next raster position: clear wins, otherwise step on advance, else hold.
  always_comb begin
    x_nxt_c     = x;
    y_nxt_c     = y;
    bar_nxt_c   = bar;
    bar_cnt_nxt = bar_cnt;
    if (clear) begin
      x_nxt_c     = '0;
      y_nxt_c     = '0;
      bar_nxt_c   = '0;
      bar_cnt_nxt = '0;
    end else if (advance) begin
      if (x == X_MAX) begin
        x_nxt_c     = '0;
        bar_nxt_c   = '0;
        bar_cnt_nxt = '0;
        y_nxt_c     = (y == Y_MAX) ? '0 : y + Y_BITS'(1);
      end else begin
        x_nxt_c = x + X_BITS'(1);
        if (bar_cnt == BAR_CNT_MAX) begin
          bar_cnt_nxt = '0;
          if (bar != BAR_MAX) begin
            bar_nxt_c = bar + BAR_IDX_BITS'(1);
          end
        end else begin
          bar_cnt_nxt = bar_cnt + BAR_CNT_BITS'(1);
        end
      end
    end
    last_nxt = (x_nxt_c == X_MAX) && (y_nxt_c == Y_MAX);
  end

  // Position registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      x       <= '0;
      y       <= '0;
      bar     <= '0;
      bar_cnt <= '0;
      last    <= 1'b0;
    end else begin
      x       <= x_nxt_c;
      y       <= y_nxt_c;
      bar     <= bar_nxt_c;
      bar_cnt <= bar_cnt_nxt;
      last    <= last_nxt;
    end
  end

endmodule

// File: rtl/gfx_pattern_gen.sv
// Multi-mode pixel-stream source: emits raster frames of (x, y, color, last)
// beats on a pvalid/pready handshake, with optional back-to-back frame repeat.
// Optional build macro GFX_PATTERN_GEN_ANIMATE_EN: offsets the gradient and
// checker patterns by the frame count for a one-pixel-per-frame scroll.
module gfx_pattern_gen
  import gfx_pattern_pkg::*;
#(
  parameter int unsigned              FB_WIDTH    = 640,
  parameter int unsigned              FB_HEIGHT   = 480,
  parameter int unsigned              PIXEL_BITS  = 12,
  parameter logic [PIXEL_BITS-1:0]    SOLID_COLOR = PIXEL_BITS'(12'hF00),
  parameter int unsigned              CHECK_SHIFT = 3,
  localparam int unsigned             COLOR_BITS  = PIXEL_BITS / 3,
  localparam int unsigned             FB_X_BITS   = $clog2(FB_WIDTH),
  localparam int unsigned             FB_Y_BITS   = $clog2(FB_HEIGHT)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  mode_t                 mode,
  input  logic                  start,
  input  logic                  repeat_en,
  input  logic                  pready,
  output logic                  pvalid,
  output logic [FB_X_BITS-1:0]  x,
  output logic [FB_Y_BITS-1:0]  y,
  output logic [PIXEL_BITS-1:0] color,
  output logic                  last,
  output logic                  busy,
  output logic                  frame_done
);

  state_t                  state;
  mode_t                   mode_q;
  logic [FB_X_BITS-1:0]    frame_cnt;

  logic                    fire_c;
  logic                    last_fire_c;
  logic                    clear_c;
  logic                    frame_start_c;
  logic                    run_nxt_c;
  mode_t                   mode_nxt_c;
  logic [FB_X_BITS-1:0]    frame_cnt_nxt_c;
  logic [FB_X_BITS-1:0]    x_nxt_c;
  logic [FB_Y_BITS-1:0]    y_nxt_c;
  logic [BAR_IDX_BITS-1:0] bar_nxt_c;
  logic [FB_X_BITS-1:0]    xe_c;
  logic [COLOR_BITS-1:0]   grad_c;
  logic                    chk_c;
  logic [BAR_IDX_BITS-1:0] bar_k_c;
  logic [PIXEL_BITS-1:0]   color_nxt_c;

  assign fire_c          = pvalid && pready;
  assign last_fire_c     = fire_c && last;
  assign clear_c         = (state == IDLE) && start;
  assign frame_start_c   = clear_c || (last_fire_c && repeat_en);
  assign run_nxt_c       = (state == IDLE) ? start : !(last_fire_c && !repeat_en);
  assign mode_nxt_c      = frame_start_c ? mode : mode_q;
  assign frame_cnt_nxt_c = last_fire_c ? frame_cnt + FB_X_BITS'(1) : frame_cnt;

  gfx_raster_counter #(
    .FB_WIDTH  (FB_WIDTH),
    .FB_HEIGHT (FB_HEIGHT),
    .X_BITS    (FB_X_BITS),
    .Y_BITS    (FB_Y_BITS)
  ) u_raster (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear_c),
    .advance   (fire_c),
    .x         (x),
    .y         (y),
    .last      (last),
    .x_nxt_c   (x_nxt_c),
    .y_nxt_c   (y_nxt_c),
    .bar_nxt_c (bar_nxt_c)
  );

  // Effective x for the position-derived patterns.
`ifdef GFX_PATTERN_GEN_ANIMATE_EN
  assign xe_c = x_nxt_c + frame_cnt_nxt_c;
`else
  assign xe_c = x_nxt_c;
`endif

  // Colour of the next beat, computed from next-cycle coordinates and mode.
  always_comb begin
    grad_c      = COLOR_BITS'({xe_c, COLOR_BITS'(0)} >> FB_X_BITS);
    chk_c       = (|((xe_c >> CHECK_SHIFT) & FB_X_BITS'(1))) ^
                  (|((y_nxt_c >> CHECK_SHIFT) & FB_Y_BITS'(1)));
    bar_k_c     = ~bar_nxt_c;
    color_nxt_c = '0;
    case (mode_nxt_c)
      MODE_SOLID:   color_nxt_c = SOLID_COLOR;
      MODE_HGRAD:   color_nxt_c = {grad_c, grad_c, grad_c};
      MODE_CHECKER: color_nxt_c = {PIXEL_BITS{chk_c}};
      MODE_BARS:    color_nxt_c = {{COLOR_BITS{bar_k_c[2]}}, {COLOR_BITS{bar_k_c[1]}},
                                   {COLOR_BITS{bar_k_c[0]}}};
      default:      color_nxt_c = '0;
    endcase
  end

  // Frame FSM with registered handshake, status and colour outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      pvalid     <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      color      <= '0;
      mode_q     <= MODE_SOLID;
      frame_cnt  <= '0;
    end else begin
      frame_done <= last_fire_c;
      frame_cnt  <= frame_cnt_nxt_c;
      mode_q     <= mode_nxt_c;
      color      <= run_nxt_c ? color_nxt_c : '0;
      case (state)
        IDLE: begin
          if (start) begin
            state  <= RUN;
            pvalid <= 1'b1;
            busy   <= 1'b1;
          end
        end
        RUN: begin
          if (last_fire_c && !repeat_en) begin
            state  <= IDLE;
            pvalid <= 1'b0;
            busy   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gfx_pattern_gen.sv
// Directed self-checking bench for gfx_pattern_gen on a 16x4 frame.
module tb_gfx_pattern_gen;
  import gfx_pattern_pkg::*;

  localparam int W = 16;
  localparam int H = 4;
  localparam int NPIX = W * H;
`ifdef GFX_PATTERN_GEN_ANIMATE_EN
  localparam bit ANIM = 1'b1;
`else
  localparam bit ANIM = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        start;
  logic        repeat_en;
  logic        pready;
  mode_t       mode;
  logic        pvalid;
  logic [3:0]  x;
  logic [1:0]  y;
  logic [11:0] color;
  logic        last;
  logic        busy;
  logic        frame_done;

  int checks = 0;
  int failures = 0;

  logic [3:0]  bx [128];
  logic [1:0]  by [128];
  logic [11:0] bc [128];
  logic        bl [128];
  int          bcyc [128];

  gfx_pattern_gen #(
    .FB_WIDTH    (16),
    .FB_HEIGHT   (4),
    .PIXEL_BITS  (12),
    .SOLID_COLOR (12'hF00),
    .CHECK_SHIFT (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .mode       (mode),
    .start      (start),
    .repeat_en  (repeat_en),
    .pready     (pready),
    .pvalid     (pvalid),
    .x          (x),
    .y          (y),
    .color      (color),
    .last       (last),
    .busy       (busy),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference colour for a pixel; fc = frames completed since reset.
  function automatic logic [11:0] exp_color(input int m, input int xx, input int yy, input int fc);
    int xe;
    logic [3:0] c;
    logic [2:0] k;
    xe = ANIM ? ((xx + fc) % W) : xx;
    c = 4'(xe);
    k = 3'(7 - xx / 2);
    case (m)
      0: return 12'hF00;
      1: return {c, c, c};
      2: return ((((xe / 4) % 2) ^ ((yy / 4) % 2)) != 0) ? 12'hFFF : 12'h000;
      default: return {{4{k[2]}}, {4{k[1]}}, {4{k[0]}}};
    endcase
  endfunction

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; pready = 1'b0; repeat_en = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // Captures one frame's accepted beats; caller raises start beforehand.
  task automatic collect_frame(input bit rnd, input int budget,
                               output int n, output bit timeout, output bit unstable);
    bit stalled;
    logic [3:0] px; logic [1:0] py; logic [11:0] pc; logic pl;
    n = 0; timeout = 1'b1; unstable = 1'b0; stalled = 1'b0;
    px = '0; py = '0; pc = '0; pl = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      pready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (stalled && (x !== px || y !== py || color !== pc || last !== pl || pvalid !== 1'b1))
        unstable = 1'b1;
      stalled = 1'b0;
      if (pvalid && pready) begin
        if (n < 128) begin
          bx[n] = x; by[n] = y; bc[n] = color; bl[n] = last; bcyc[n] = c;
        end
        n++;
        if (last) begin timeout = 1'b0; break; end
      end else if (pvalid) begin
        stalled = 1'b1; px = x; py = y; pc = color; pl = last;
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (pvalid !== 1'b0) begin failures++; $display("FAIL reset_pvalid got=%b want=0", pvalid); end
    checks++; if (x !== 4'd0) begin failures++; $display("FAIL reset_x got=%0d want=0", x); end
    checks++; if (y !== 2'd0) begin failures++; $display("FAIL reset_y got=%0d want=0", y); end
    checks++; if (color !== 12'h000) begin failures++; $display("FAIL reset_color got=%h want=000", color); end
    checks++; if (last !== 1'b0) begin failures++; $display("FAIL reset_last got=%b want=0", last); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL reset_frame_done got=%b want=0", frame_done); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (pvalid !== 1'b0) begin failures++; $display("FAIL idle_no_start got=%b want=0", pvalid); end
  endtask

  task automatic test_solid();
    int n, bad; bit to, us;
    do_reset();
    mode = MODE_SOLID; start = 1'b1;
    collect_frame(1'b0, 300, n, to, us);
    checks++; if (to) begin failures++; $display("FAIL solid_timeout got=%0d beats want=%0d", n, NPIX); end
    checks++; if (n !== NPIX) begin failures++; $display("FAIL solid_beats got=%0d want=%0d", n, NPIX); end
    checks++; if (bx[0] !== 4'd0 || by[0] !== 2'd0 || bc[0] !== 12'hF00) begin
      failures++; $display("FAIL solid_first got=(%0d,%0d,%h) want=(0,0,f00)", bx[0], by[0], bc[0]); end
    bad = 0;
    for (int i = 0; i < NPIX; i++)
      if (bx[i] !== 4'(i % W) || by[i] !== 2'(i / W) || bc[i] !== 12'hF00 || bl[i] !== (i == NPIX - 1)) bad++;
    checks++; if (bad != 0) begin failures++; $display("FAIL solid_raster bad_beats=%0d want=0", bad); end
    checks++; if (bx[63] !== 4'd15 || by[63] !== 2'd3 || bl[63] !== 1'b1) begin
      failures++; $display("FAIL solid_last got=(%0d,%0d,last=%b) want=(15,3,1)", bx[63], by[63], bl[63]); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL solid_busy_at_last got=%b want=1", busy); end
    @(posedge clk); #1;
    checks++; if (frame_done !== 1'b1) begin failures++; $display("FAIL solid_done_pulse got=%b want=1", frame_done); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL solid_busy_drop got=%b want=0", busy); end
    checks++; if (pvalid !== 1'b0) begin failures++; $display("FAIL solid_pvalid_end got=%b want=0", pvalid); end
    @(posedge clk); #1;
    checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL solid_done_width got=%b want=0", frame_done); end
  endtask

  task automatic test_stall();
    int n, bad, badh; bit to, us;
    do_reset();
    mode = MODE_HGRAD; start = 1'b1;
    collect_frame(1'b1, 2000, n, to, us);
    checks++; if (to || n !== NPIX) begin failures++; $display("FAIL stall_beats got=%0d timeout=%b want=%0d", n, to, NPIX); end
    checks++; if (us) begin failures++; $display("FAIL stall_stable got=unstable want=stable"); end
    bad = 0; badh = 0;
    for (int i = 0; i < NPIX; i++) begin
      if (bx[i] !== 4'(i % W) || by[i] !== 2'(i / W) || bc[i] !== exp_color(1, i % W, i / W, 0)) bad++;
      if (i % W == 5 && bc[i] !== 12'h555) badh++;
      if (i % W == 15 && bc[i] !== 12'hFFF) badh++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL stall_raster bad_beats=%0d want=0", bad); end
    checks++; if (badh != 0) begin failures++; $display("FAIL hgrad_points bad=%0d want=0", badh); end
  endtask

  task automatic test_checker();
    int n, bad; bit to, us;
    int idx [4] = '{0, 4, 20, 8};
    logic [11:0] ex [4] = '{12'h000, 12'hFFF, 12'hFFF, 12'h000};
    do_reset();
    mode = MODE_CHECKER; start = 1'b1;
    collect_frame(1'b0, 300, n, to, us);
    checks++; if (to || n !== NPIX) begin failures++; $display("FAIL checker_beats got=%0d want=%0d", n, NPIX); end
    bad = 0;
    for (int i = 0; i < NPIX; i++) if (bc[i] !== exp_color(2, i % W, i / W, 0)) bad++;
    checks++; if (bad != 0) begin failures++; $display("FAIL checker_frame bad_beats=%0d want=0", bad); end
    for (int j = 0; j < 4; j++) begin
      checks++;
      if (bc[idx[j]] !== ex[j]) begin
        failures++; $display("FAIL checker_pt%0d got=%h want=%h", j, bc[idx[j]], ex[j]); end
    end
  endtask

  task automatic test_bars();
    int n, bad; bit to, us;
    int idx [6] = '{0, 1, 2, 4, 14, 15};
    logic [11:0] ex [6] = '{12'hFFF, 12'hFFF, 12'hFF0, 12'hF0F, 12'h000, 12'h000};
    do_reset();
    mode = MODE_BARS; start = 1'b1;
    collect_frame(1'b0, 300, n, to, us);
    checks++; if (to || n !== NPIX) begin failures++; $display("FAIL bars_beats got=%0d want=%0d", n, NPIX); end
    bad = 0;
    for (int i = 0; i < NPIX; i++) if (bc[i] !== exp_color(3, i % W, i / W, 0)) bad++;
    checks++; if (bad != 0) begin failures++; $display("FAIL bars_frame bad_beats=%0d want=0", bad); end
    for (int j = 0; j < 6; j++) begin
      checks++;
      if (bc[idx[j]] !== ex[j]) begin
        failures++; $display("FAIL bars_x%0d got=%h want=%h", idx[j], bc[idx[j]], ex[j]); end
    end
  endtask

  task automatic test_back_to_back();
    int n, fd, bad1, bad2; bit done;
    logic [11:0] first2;
    do_reset();
    mode = MODE_SOLID; repeat_en = 1'b1; start = 1'b1;
    n = 0; fd = 0; done = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      start = 1'b0; pready = 1'b1;
      if (frame_done) fd++;
      if (pvalid) begin
        if (n == 64) repeat_en = 1'b0;
        bx[n] = x; by[n] = y; bc[n] = color; bl[n] = last; bcyc[n] = c;
        n++;
        if (n == 20) mode = MODE_HGRAD;
        if (last && n == 128) begin done = 1'b1; break; end
      end
    end
    @(posedge clk); #1;
    if (frame_done) fd++;
    checks++; if (!done) begin failures++; $display("FAIL repeat_timeout got=%0d beats want=128", n); end
    bad1 = 0; bad2 = 0;
    for (int i = 0; i < NPIX; i++) begin
      if (bc[i] !== 12'hF00 || bl[i] !== (i == NPIX - 1)) bad1++;
      if (bx[NPIX + i] !== 4'(i % W) || by[NPIX + i] !== 2'(i / W) ||
          bc[NPIX + i] !== exp_color(1, i % W, i / W, 1)) bad2++;
    end
    checks++; if (bad1 != 0) begin failures++; $display("FAIL repeat_frame1 bad_beats=%0d want=0", bad1); end
    checks++; if (bad2 != 0) begin failures++; $display("FAIL repeat_frame2 bad_beats=%0d want=0", bad2); end
    first2 = ANIM ? 12'h111 : 12'h000;
    checks++; if (bx[64] !== 4'd0 || by[64] !== 2'd0 || bc[64] !== first2) begin
      failures++; $display("FAIL repeat_first got=(%0d,%0d,%h) want=(0,0,%h)", bx[64], by[64], bc[64], first2); end
    checks++; if (bcyc[64] !== bcyc[63] + 1) begin
      failures++; $display("FAIL repeat_gap got=%0d want=%0d", bcyc[64], bcyc[63] + 1); end
    checks++; if (fd !== 2) begin failures++; $display("FAIL repeat_done_pulses got=%0d want=2", fd); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL repeat_busy_end got=%b want=0", busy); end
  endtask

  task automatic test_start_busy();
    int cyc; bit done;
    do_reset();
    mode = MODE_SOLID; pready = 1'b1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    checks++; if (x !== 4'd2 || pvalid !== 1'b1 || busy !== 1'b1) begin
      failures++; $display("FAIL start_busy_ignored got=(x=%0d,v=%b,b=%b) want=(2,1,1)", x, pvalid, busy); end
    cyc = -1; done = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(posedge clk); #1;
      if (!busy) begin cyc = c; done = 1'b1; break; end
    end
    checks++; if (!done || cyc !== 61) begin failures++; $display("FAIL start_busy_len got=%0d want=61", cyc); end
    checks++; if (frame_done !== 1'b1) begin failures++; $display("FAIL start_busy_done got=%b want=1", frame_done); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (pvalid !== 1'b0) begin failures++; $display("FAIL start_busy_queued got=%b want=0", pvalid); end
  endtask

  task automatic test_reset_mid();
    int n, bad; bit to, us;
    do_reset();
    mode = MODE_SOLID; start = 1'b1; n = 0;
    for (int c = 0; c < 200; c++) begin
      @(posedge clk); #1;
      start = 1'b0; pready = 1'b1;
      if (pvalid) n++;
      if (n == 30) break;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checks++; if (pvalid !== 1'b0 || x !== 4'd0 || y !== 2'd0 || busy !== 1'b0 || last !== 1'b0 || color !== 12'h000) begin
      failures++; $display("FAIL midreset_outputs got=(v=%b,x=%0d,y=%0d,b=%b,l=%b,c=%h) want=(0,0,0,0,0,000)",
                           pvalid, x, y, busy, last, color); end
    start = 1'b1;
    collect_frame(1'b0, 300, n, to, us);
    checks++; if (to || n !== NPIX) begin failures++; $display("FAIL midreset_beats got=%0d want=%0d", n, NPIX); end
    bad = 0;
    for (int i = 0; i < NPIX; i++)
      if (bx[i] !== 4'(i % W) || by[i] !== 2'(i / W) || bc[i] !== 12'hF00 || bl[i] !== (i == NPIX - 1)) bad++;
    checks++; if (bad != 0) begin failures++; $display("FAIL midreset_frame bad_beats=%0d want=0", bad); end
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; repeat_en = 1'b0; pready = 1'b0; mode = MODE_SOLID;
    test_reset();
    test_solid();
    test_stall();
    test_checker();
    test_bars();
    test_back_to_back();
    test_start_busy();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
